regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
- Shares the register file's single write port (id with MSB-disable, value) between NREQ requesters, e.g. ALU writeback and load unit.
- Round-robin arbitration with a per-requester valid/ready handshake.
- Registered write-port outputs; a stall input blocks all writes.
- Sits between execution units and the register file write inputs.

Parameters:
N, 32, data width (matches register file)
M, 2, register id width; 2**M registers
NREQ, 2, number of requesters (2..8)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  NREQ  requester i has a write pending
req_id  input  NREQ*M  target register of requester i, slice [i*M +: M]
req_data  input  NREQ*N  write value of requester i, slice [i*N +: N]
req_ready  output  NREQ  one-hot (or zero); transfer when valid&ready
stall  input  1  1 = accept nothing this cycle
wr_id  output  M+1  register-file write id; MSB=1 means no write
wr_data  output  N  register-file write value
wr_count  output  16  number of accepted writes, saturating at 16'hFFFF

Behaviour:
- Interface decided: one clock clk; rst asynchronous, active-high.
- Reset (async, any cycle incl. mid-transfer):
  - wr_id = {1'b1, M'b0}; wr_data = 0; wr_count = 0; rr pointer = 0; lock state cleared.
  - A transfer whose accepting clock edge has not occurred is lost.
- Grant (combinational):
  - If stall=0 and some req_valid=1, grant the first valid index searching ptr, ptr+1, ..., wrapping modulo NREQ.
  - req_ready is one-hot on the granted index and 0 elsewhere.
  - req_ready never depends on req_valid of the granted requester beyond the selection itself.
- Accept (at the clk edge where valid&ready):
  - wr_id <= {1'b0, req_id[g]}; wr_data <= req_data[g]; latency 1 cycle from accept to write port.
  - ptr <= (g+1) mod NREQ; wr_count increments unless already 16'hFFFF.
- No accept (no valid, or stall=1):
  - wr_id <= {1'b1, M'b0}; wr_data holds its previous value; ptr unchanged; wr_count unchanged.
- Simultaneous requests to the same register id are not merged; they are serialized in grant order, so the last granted requester wins.
- Throughput is 1 write/cycle with no bubbles between back-to-back grants.
- Requesters hold valid, id and data stable until ready; a deasserted valid without ready is legal (request withdrawn).

Optional Feature:
- Macro REGFILE_ARB_LOCK_EN adds input req_lock [NREQ].
- With the macro: two-state FSM UNLOCKED/LOCKED.
  - In UNLOCKED, an accept with req_lock[g]=1 moves to LOCKED with owner=g.
  - In LOCKED, only the owner can be granted and ptr does not advance.
  - LOCKED returns to UNLOCKED on the first owner accept with req_lock[owner]=0, or on a cycle with req_valid[owner]=0 and stall=0.
  - stall does not break the lock; rst forces UNLOCKED.
- Without the macro: no req_lock port and no FSM; pure round-robin.

Decomposition:
- Package regfile_pkg holds:
  - default N/M constants;
  - localparam WR_DISABLE = {1'b1, M'b0} pattern helper;
  - count width 16 and saturation value;
  - lock state enum (UNLOCKED, LOCKED).
- Sub-module rr_picker (combinational; inputs valid mask and ptr; outputs one-hot grant and index) isolates the wrap-around search for separate unit test.

Test Plan:
- Reset: assert rst mid-cycle with valid=2'b11 -> immediately wr_id=3'b100, wr_count=0; after release the first grant goes to requester 0.
- Contention, NREQ=2, both valid continuously, req_id0=1/data 0xAAAA, req_id1=2/data 0x5555 -> ready alternates 01,10,01; wr_id sequence 001,010,001 one cycle later; wr_count +1 per cycle.
- Stall: both valid, stall=1 for 3 cycles -> ready=00, wr_id=3'b100 for 3 cycles, ptr unchanged; the grant after stall goes to the same requester as before stall.
- Wrap-around, NREQ=4, ptr=3, valid=4'b0001 -> grant index 0, next ptr=1.
- Saturation: preload by running 65535 accepts, one more accept -> wr_count stays 16'hFFFF.
- REGFILE_ARB_LOCK_EN: requester 1 accepts with lock=1 for 3 writes while requester 0 valid -> ready stays 10 for all 3; then lock=0 on the 4th accept -> the next grant goes to requester 0.

Source files
------------

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
// Optional lock mode is enabled by defining REGFILE_ARB_LOCK_EN.
package regfile_pkg;

  localparam int unsigned N_DEFAULT = 32;
  localparam int unsigned M_DEFAULT = 2;

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Write-disable id: MSB set, register bits zero.
  function automatic logic [31:0] wr_disable(input int unsigned m);
    return 32'(1) << m;
  endfunction

  localparam logic [M_DEFAULT:0] WR_DISABLE = (M_DEFAULT + 1)'(wr_disable(M_DEFAULT));

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Requester / write-port bundle for regfile_wr_arbiter.
// req_lock exists only when REGFILE_ARB_LOCK_EN is defined.
interface regfile_wr_arbiter_if #(
    parameter int unsigned N    = 32,
    parameter int unsigned M    = 2,
    parameter int unsigned NREQ = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*M-1:0] req_id;
    logic [NREQ*N-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              stall;
    logic [M:0]        wr_id;
    logic [N-1:0]      wr_data;
    logic [15:0]       wr_count;
`ifdef REGFILE_ARB_LOCK_EN
    logic [NREQ-1:0]   req_lock;

    modport master (
        output req_valid, req_id, req_data, stall, req_lock,
        input  req_ready, wr_id, wr_data, wr_count
    );
    modport slave (
        input  req_valid, req_id, req_data, stall, req_lock,
        output req_ready, wr_id, wr_data, wr_count
    );
`else
    modport master (
        output req_valid, req_id, req_data, stall,
        input  req_ready, wr_id, wr_data, wr_count
    );
    modport slave (
        input  req_valid, req_id, req_data, stall,
        output req_ready, wr_id, wr_data, wr_count
    );
`endif
endinterface

// File: rtl/regfile_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: first set bit of valid at or after ptr,
// wrapping modulo NREQ.
module rr_picker #(
    parameter int unsigned NREQ = 2,
    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IdxW-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [IdxW-1:0] idx,
    output logic            any
);
    logic [IdxW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IdxW'((32'(ptr) + i) % NREQ);
            if (!any && valid[cand]) begin
                any         = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing one register-file write port between NREQ requesters.
// Define REGFILE_ARB_LOCK_EN to add the req_lock ownership mode.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned N    = N_DEFAULT,
    parameter int unsigned M    = M_DEFAULT,
    parameter int unsigned NREQ = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wr_arbiter_if.slave  bus
);
    localparam int unsigned IdxW = $clog2(NREQ);
    localparam logic [M:0] WrDisable = (M + 1)'(wr_disable(M));

    logic [IdxW-1:0]  ptr_q, ptr_d;
    logic [M:0]       wr_id_q, wr_id_d;
    logic [N-1:0]     wr_data_q, wr_data_d;
    logic [CNT_W-1:0] wr_count_q, wr_count_d;

    logic [NREQ-1:0]  mask;
    logic [NREQ-1:0]  grant;
    logic [IdxW-1:0]  idx;
    logic             accept;
    logic             ptr_hold;

`ifdef REGFILE_ARB_LOCK_EN
    lock_state_e      state_q, state_d;
    logic [IdxW-1:0]  owner_q, owner_d;
`endif

    always_comb begin
        mask     = bus.stall ? '0 : bus.req_valid;
        ptr_hold = 1'b0;
`ifdef REGFILE_ARB_LOCK_EN
        // While locked, only the owner is eligible and the pointer is frozen.
        if (state_q == LOCKED) begin
            mask     = mask & (NREQ'(1) << owner_q);
            ptr_hold = 1'b1;
        end
`endif
    end

    rr_picker #(
        .NREQ(NREQ)
    ) u_picker (
        .valid(mask),
        .ptr  (ptr_q),
        .grant(grant),
        .idx  (idx),
        .any  (accept)
    );

    assign bus.req_ready = grant;

    always_comb begin
        ptr_d      = ptr_q;
        wr_id_d    = WrDisable;
        wr_data_d  = wr_data_q;
        wr_count_d = wr_count_q;
        if (accept) begin
            wr_id_d   = {1'b0, bus.req_id[idx*M +: M]};
            wr_data_d = bus.req_data[idx*N +: N];
            if (!ptr_hold) begin
                ptr_d = IdxW'((32'(idx) + 1) % NREQ);
            end
            if (wr_count_q != CNT_MAX) begin
                wr_count_d = wr_count_q + 1'b1;
            end
        end
    end

`ifdef REGFILE_ARB_LOCK_EN
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        unique case (state_q)
            UNLOCKED: begin
                if (accept && bus.req_lock[idx]) begin
                    state_d = LOCKED;
                    owner_d = idx;
                end
            end
            LOCKED: begin
                if (accept && !bus.req_lock[owner_q]) begin
                    state_d = UNLOCKED;
                end else if (!bus.stall && !bus.req_valid[owner_q]) begin
                    state_d = UNLOCKED;
                end
            end
            default: state_d = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= UNLOCKED;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            wr_id_q    <= WrDisable;
            wr_data_q  <= '0;
            wr_count_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            wr_id_q    <= wr_id_d;
            wr_data_q  <= wr_data_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign bus.wr_id    = wr_id_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.wr_count = wr_count_q;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed self-checking bench for regfile_wr_arbiter and its rr_picker.
// Lock-mode steps run only when REGFILE_ARB_LOCK_EN is defined.
module tb_regfile_wr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    regfile_wr_arbiter_if #(.N(32), .M(2), .NREQ(2)) bus ();

    regfile_wr_arbiter #(
        .N   (32),
        .M   (2),
        .NREQ(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [3:0] pk_valid;
    logic [1:0] pk_ptr;
    logic [3:0] pk_grant;
    logic [1:0] pk_idx;
    logic       pk_any;

    rr_picker #(
        .NREQ(4)
    ) u_pk (
        .valid(pk_valid),
        .ptr  (pk_ptr),
        .grant(pk_grant),
        .idx  (pk_idx),
        .any  (pk_any)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_id    = {2'd2, 2'd1};
        bus.req_data  = {32'h0000_5555, 32'h0000_AAAA};
        bus.stall     = 1'b0;
`ifdef REGFILE_ARB_LOCK_EN
        bus.req_lock  = '0;
`endif
        pk_valid = '0;
        pk_ptr   = '0;

        // Reset state
        #12;
        check("rst_wr_id", 64'(bus.wr_id), 64'h4);
        check("rst_wr_data", 64'(bus.wr_data), 64'h0);
        check("rst_wr_count", 64'(bus.wr_count), 64'h0);
        check("rst_ready", 64'(bus.req_ready), 64'h0);
        rst = 1'b0;

        // Contention: alternating grants, one-cycle write latency
        bus.req_valid = 2'b11;
        #1;
        check("cont_ready0", 64'(bus.req_ready), 64'h1);
        tick();
        check("cont_id0", 64'(bus.wr_id), 64'h1);
        check("cont_data0", 64'(bus.wr_data), 64'hAAAA);
        check("cont_cnt0", 64'(bus.wr_count), 64'd1);
        check("cont_ready1", 64'(bus.req_ready), 64'h2);
        tick();
        check("cont_id1", 64'(bus.wr_id), 64'h2);
        check("cont_data1", 64'(bus.wr_data), 64'h5555);
        check("cont_cnt1", 64'(bus.wr_count), 64'd2);
        check("cont_ready2", 64'(bus.req_ready), 64'h1);
        tick();
        check("cont_id2", 64'(bus.wr_id), 64'h1);
        check("cont_cnt2", 64'(bus.wr_count), 64'd3);
        check("cont_ready3", 64'(bus.req_ready), 64'h2);

        // Stall for three cycles: nothing accepted, data held, pointer kept
        bus.stall = 1'b1;
        #1;
        check("stall_ready", 64'(bus.req_ready), 64'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("stall_id", 64'(bus.wr_id), 64'h4);
            check("stall_data", 64'(bus.wr_data), 64'hAAAA);
            check("stall_cnt", 64'(bus.wr_count), 64'd3);
        end
        bus.stall = 1'b0;
        #1;
        check("post_stall_ready", 64'(bus.req_ready), 64'h2);
        tick();
        check("post_stall_id", 64'(bus.wr_id), 64'h2);
        check("post_stall_cnt", 64'(bus.wr_count), 64'd4);

        // Single requester found by wrapping past an idle pointer slot
        bus.req_valid = 2'b10;
        #1;
        check("single_ready", 64'(bus.req_ready), 64'h2);
        tick();
        check("single_id", 64'(bus.wr_id), 64'h2);
        check("single_cnt", 64'(bus.wr_count), 64'd5);

        // Idle: write disabled, data held
        bus.req_valid = 2'b00;
        #1;
        check("idle_ready", 64'(bus.req_ready), 64'h0);
        tick();
        check("idle_id", 64'(bus.wr_id), 64'h4);
        check("idle_data", 64'(bus.wr_data), 64'h5555);
        check("idle_cnt", 64'(bus.wr_count), 64'd5);

        // Mid-cycle asynchronous reset with both requesting
        bus.req_valid = 2'b11;
        #2;
        rst = 1'b1;
        #1;
        check("arst_id", 64'(bus.wr_id), 64'h4);
        check("arst_data", 64'(bus.wr_data), 64'h0);
        check("arst_cnt", 64'(bus.wr_count), 64'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_first_ready", 64'(bus.req_ready), 64'h1);
        tick();
        check("arst_first_id", 64'(bus.wr_id), 64'h1);
        check("arst_first_cnt", 64'(bus.wr_count), 64'd1);

        // Saturation: run the counter up to 16'hFFFF and one beyond
        bus.req_valid = 2'b01;
        repeat (65534) @(posedge clk);
        #1;
        check("sat_reach", 64'(bus.wr_count), 64'hFFFF);
        tick();
        check("sat_hold", 64'(bus.wr_count), 64'hFFFF);
        check("sat_id", 64'(bus.wr_id), 64'h1);

        // Picker wrap-around with NREQ=4
        pk_valid = 4'b0001;
        pk_ptr   = 2'd3;
        #1;
        check("pk_wrap_grant", 64'(pk_grant), 64'h1);
        check("pk_wrap_idx", 64'(pk_idx), 64'd0);
        pk_valid = 4'b1010;
        pk_ptr   = 2'd2;
        #1;
        check("pk_skip_idx", 64'(pk_idx), 64'd3);
        check("pk_skip_grant", 64'(pk_grant), 64'h8);
        pk_valid = 4'b1111;
        pk_ptr   = 2'd1;
        #1;
        check("pk_all_idx", 64'(pk_idx), 64'd1);
        pk_valid = 4'b0000;
        #1;
        check("pk_none_any", 64'(pk_any), 64'd0);
        check("pk_none_grant", 64'(pk_grant), 64'h0);

`ifdef REGFILE_ARB_LOCK_EN
        // Lock: requester 1 holds the port until it drops req_lock
        bus.req_valid = 2'b00;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        bus.req_lock  = 2'b10;
        bus.req_valid = 2'b10;
        #1;
        check("lock_ready0", 64'(bus.req_ready), 64'h2);
        tick();
        bus.req_valid = 2'b11;
        #1;
        check("lock_ready1", 64'(bus.req_ready), 64'h2);
        tick();
        check("lock_ready2", 64'(bus.req_ready), 64'h2);
        tick();
        check("lock_ready3", 64'(bus.req_ready), 64'h2);
        bus.req_lock = 2'b00;
        tick();
        check("unlock_ready", 64'(bus.req_ready), 64'h1);
        check("lock_cnt", 64'(bus.wr_count), 64'd4);
        check("lock_id", 64'(bus.wr_id), 64'h2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
